// File: rtl/ahb_gpio_pkg.sv
// Shared AHB-Lite definitions for the GPIO-side transfer engine.
// Holds the HTRANS encoding and the default bus widths and wait-state limit.
package ahb_gpio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam int AHB_ADDR_WIDTH     = 32;
    localparam int AHB_DATA_WIDTH     = 32;
    localparam int AHB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/ahb_timeout_ctr.sv
// Wait-state counter for the data phase; raises timeout on the last permitted
// stalled edge so the master can abort the transfer.
module ahb_timeout_ctr
    import ahb_gpio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = AHB_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic d_vld,
    input  logic hreadyout,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign timeout = d_vld && !hreadyout && (count == LIMIT);

    // A forced completion clears the count just like a normal one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (d_vld && (hreadyout || timeout)) begin
            count <= '0;
        end else if (d_vld) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_gpio_master.sv
// Pipelined AHB-Lite single-transfer master in front of the GPIO slave.
// Define AHB_MASTER_TIMEOUT_EN to abort data phases stalled for TIMEOUT_CYCLES.
module ahb_gpio_master
    import ahb_gpio_pkg::*;
#(
    parameter int ADDR_WIDTH     = AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = AHB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = AHB_TIMEOUT_CYCLES
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic                  HSEL,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HREADY,
    input  logic                  HREADYOUT,
    input  logic [DATA_WIDTH-1:0] HRDATA
);

    logic                  a_vld;
    logic                  a_write;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  d_vld;
    logic                  d_write;
    logic                  adv;
    logic                  accept;
    logic                  done;
    logic                  timeout_hit;

`ifdef AHB_MASTER_TIMEOUT_EN
    ahb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk       (HCLK),
        .rst       (HRESET),
        .d_vld     (d_vld),
        .hreadyout (HREADYOUT),
        .timeout   (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // The forced advance is internal only; the slave keeps seeing its own HREADYOUT.
    assign HREADY    = HREADYOUT;
    assign adv       = HREADYOUT || timeout_hit;
    assign cmd_ready = !HRESET && (!a_vld || adv);
    assign accept    = cmd_valid && cmd_ready;
    assign done      = d_vld && adv;

    assign HTRANS = a_vld ? NONSEQ : IDLE;
    assign HSEL   = a_vld;
    assign HWRITE = a_vld && a_write;
    assign HADDR  = a_addr;

    // An accept while the slot is empty can land during a stalled data phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_vld   <= 1'b0;
            a_write <= 1'b0;
            a_addr  <= '0;
            a_wdata <= '0;
        end else if (accept) begin
            a_vld   <= 1'b1;
            a_write <= cmd_write;
            a_addr  <= cmd_addr;
            a_wdata <= cmd_wdata;
        end else if (adv) begin
            a_vld   <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            d_vld   <= 1'b0;
            d_write <= 1'b0;
            HWDATA  <= '0;
        end else if (adv) begin
            d_vld   <= a_vld;
            d_write <= a_write;
            if (a_vld && a_write) begin
                HWDATA <= a_wdata;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done;
            if (done) begin
                rsp_rdata <= (d_write || timeout_hit) ? '0 : HRDATA;
                rsp_err   <= timeout_hit;
            end
        end
    end

endmodule

// File: tb/tb_ahb_gpio_master.sv
// Directed and randomized bench for ahb_gpio_master with an in-bench slave
// memory and a command-order reference memory.
module tb_ahb_gpio_master;

    localparam int TO = 16;

    logic        HCLK;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    ahb_gpio_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSEL      (HSEL),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem [8];
    logic [31:0] slv_mem [8];
    logic [31:0] exp_q [$];
    cmd_t        bus_q [$];
    logic        s_dvld;
    logic        s_dw;
    logic [2:0]  s_idx;
    logic [31:0] s_wdata;
    int          zrun;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    // One bus cycle of the randomized phase: slave model, scoreboard, new stimulus.
    task automatic cycle(input bit rnd);
        bit   acc;
        cmd_t c;
        @(negedge HCLK);
        chk("hready_follow", 32'(HREADY), 32'(HREADYOUT));
        if (HREADYOUT) begin
            if (s_dvld && s_dw) begin
                chk("bus_hwdata", HWDATA, s_wdata);
                slv_mem[s_idx] = HWDATA;
            end
            s_dvld = 1'b0;
            if (HSEL) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_addr_phase", 32'(HSEL), 32'd0);
                end else begin
                    c = bus_q.pop_front();
                    chk("bus_htrans", 32'(HTRANS), 32'd2);
                    chk("bus_haddr", HADDR, c.addr);
                    chk("bus_hwrite", 32'(HWRITE), 32'(c.w));
                    s_dvld  = 1'b1;
                    s_dw    = HWRITE;
                    s_idx   = HADDR[4:2];
                    s_wdata = c.wdata;
                end
            end
        end
        acc = cmd_valid && cmd_ready;
        if (acc) begin
            c.w = cmd_write; c.addr = cmd_addr; c.wdata = cmd_wdata;
            bus_q.push_back(c);
            if (cmd_write) begin
                ref_mem[cmd_addr[4:2]] = cmd_wdata;
                exp_q.push_back(32'd0);
            end else begin
                exp_q.push_back(ref_mem[cmd_addr[4:2]]);
            end
        end
        step();
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                chk("rnd_rsp_rdata", rsp_rdata, exp_q.pop_front());
                chk("rnd_rsp_err", 32'(rsp_err), 32'd0);
            end
        end
        if (!rnd) begin
            cmd_valid = 1'b0;
            HREADYOUT = 1'b1;
        end else begin
            if (!cmd_valid || acc) begin
                cmd_valid = ($urandom_range(0, 3) != 0);
                cmd_write = $urandom_range(0, 1) == 1;
                cmd_addr  = 32'($urandom_range(0, 7)) << 2;
                cmd_wdata = $urandom;
            end
            if (zrun >= 3) HREADYOUT = 1'b1;
            else           HREADYOUT = ($urandom_range(0, 3) != 0);
            zrun = HREADYOUT ? 0 : zrun + 1;
        end
        HRDATA = (s_dvld && !s_dw) ? slv_mem[s_idx] : $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wd [4];
        int n_rsp;
        int n;

        HRESET    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_00F0;
        cmd_wdata = 32'h1111_2222;
        HREADYOUT = 1'b1;
        HRDATA    = 32'h0;
        #2;
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_hsel", 32'(HSEL), 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        step();
        cmd_valid = 1'b0;
        HRESET    = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single write, zero wait states
        drive_cmd(1'b1, 32'h0000_0004, 32'h0000_A5A5);
        #1;
        chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("wr_htrans", 32'(HTRANS), 32'd2);
        chk("wr_hwrite", 32'(HWRITE), 32'd1);
        chk("wr_hsel", 32'(HSEL), 32'd1);
        chk("wr_haddr", HADDR, 32'h0000_0004);
        step();
        chk("wr_htrans_idle", 32'(HTRANS), 32'd0);
        chk("wr_hwdata", HWDATA, 32'h0000_A5A5);
        chk("wr_haddr_hold", HADDR, 32'h0000_0004);
        chk("wr_rsp_early", 32'(rsp_valid), 32'd0);
        step();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_rsp_err", 32'(rsp_err), 32'd0);
        step();
        chk("wr_rsp_pulse", 32'(rsp_valid), 32'd0);

        // Single read
        drive_cmd(1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
        step();
        cmd_valid = 1'b0;
        chk("rd_htrans", 32'(HTRANS), 32'd2);
        chk("rd_hwrite", 32'(HWRITE), 32'd0);
        chk("rd_haddr", HADDR, 32'h0000_0000);
        step();
        HRDATA = 32'h0000_3C3C;
        chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
        step();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h0000_3C3C);
        HRDATA = 32'h0;

        // Four back-to-back writes
        n_rsp = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc < 4) begin
                wd[cyc] = $urandom;
                drive_cmd(1'b1, 32'h10 + 32'(cyc * 4), wd[cyc]);
                #1;
                chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
            end else begin
                cmd_valid = 1'b0;
            end
            step();
            if (cyc < 4) begin
                chk("b2b_htrans", 32'(HTRANS), 32'd2);
                chk("b2b_haddr", HADDR, 32'h10 + 32'(cyc * 4));
            end
            if (cyc >= 1 && cyc <= 4) chk("b2b_hwdata", HWDATA, wd[cyc-1]);
            if (rsp_valid) begin
                chk("b2b_rsp_cycle", 32'(cyc), 32'(n_rsp + 2));
                chk("b2b_rsp_rdata", rsp_rdata, 32'd0);
                n_rsp++;
            end
        end
        chk("b2b_rsp_count", 32'(n_rsp), 32'd4);

        // Read stalled by three wait states with further commands queued
        drive_cmd(1'b0, 32'h0000_0008, 32'h0);
        step();
        drive_cmd(1'b1, 32'h0000_000C, 32'hCAFE_0001);
        step();
        HREADYOUT = 1'b0;
        HRDATA    = 32'hDEAD_BEEF;
        drive_cmd(1'b0, 32'h0000_0010, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ws_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("ws_htrans", 32'(HTRANS), 32'd2);
            chk("ws_haddr", HADDR, 32'h0000_000C);
            chk("ws_hwrite", 32'(HWRITE), 32'd1);
            chk("ws_rsp_valid", 32'(rsp_valid), 32'd0);
            step();
        end
        HREADYOUT = 1'b1;
        HRDATA    = 32'h1234_5678;
        #1;
        chk("ws_cmd_ready_release", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("ws_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ws_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("ws_hwdata_b", HWDATA, 32'hCAFE_0001);
        chk("ws_haddr_c", HADDR, 32'h0000_0010);
        step();
        chk("ws_rsp_b_valid", 32'(rsp_valid), 32'd1);
        chk("ws_rsp_b_rdata", rsp_rdata, 32'd0);
        step();
        chk("ws_rsp_c_valid", 32'(rsp_valid), 32'd1);
        chk("ws_rsp_c_rdata", rsp_rdata, 32'h1234_5678);
        step();
        chk("ws_rsp_end", 32'(rsp_valid), 32'd0);
        HRDATA = 32'h0;

        // Reset in the middle of a transfer
        drive_cmd(1'b1, 32'h0000_0020, 32'h0000_0055);
        step();
        drive_cmd(1'b1, 32'h0000_0024, 32'h0000_0066);
        step();
        cmd_valid = 1'b0;
        chk("mr_hwdata_pre", HWDATA, 32'h0000_0055);
        chk("mr_htrans_pre", 32'(HTRANS), 32'd2);
        HRESET = 1'b1;
        #1;
        chk("mr_htrans", 32'(HTRANS), 32'd0);
        chk("mr_hsel", 32'(HSEL), 32'd0);
        chk("mr_haddr", HADDR, 32'd0);
        chk("mr_hwdata", HWDATA, 32'd0);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        HRESET = 1'b0;
        #1;
        chk("mr_cmd_ready_release", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
            chk("mr_idle", 32'(HTRANS), 32'd0);
        end

        // Slave stuck not ready
        drive_cmd(1'b0, 32'h0000_0000, 32'h0);
        HRDATA = 32'hFFFF_FFFF;
        step();
        cmd_valid = 1'b0;
        step();
        HREADYOUT = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
        n = 41;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (rsp_valid) begin
                n = k;
                break;
            end
        end
        chk("to_cycles", 32'(n), 32'(TO));
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        chk("to_hready", 32'(HREADY), 32'd0);
        HREADYOUT = 1'b1;
        step();
        chk("to_rsp_pulse", 32'(rsp_valid), 32'd0);
`else
        n = 0;
        for (int k = 0; k < 2 * TO; k++) begin
            step();
            if (rsp_valid) n++;
        end
        chk("stall_no_rsp", 32'(n), 32'd0);
        HREADYOUT = 1'b1;
        step();
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
        chk("stall_rsp_err", 32'(rsp_err), 32'd0);
`endif
        HRDATA = 32'h0;
        step();
        step();

        // Randomized traffic against the reference memory
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = 32'h0;
            slv_mem[i] = 32'h0;
        end
        s_dvld = 1'b0;
        s_dw   = 1'b0;
        s_idx  = 3'd0;
        s_wdata = 32'h0;
        zrun   = 0;
        for (int i = 0; i < 1500; i++) cycle(1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0);
        chk("rnd_rsp_drained", 32'(exp_q.size()), 32'd0);
        chk("rnd_bus_drained", 32'(bus_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
